// File: rtl/ssf_pkg.sv
// ssf_pkg: shared constants, FSM encoding and bank reset values for the SSF mapper controller.
// Rev 1.0
`default_nettype none

package ssf_pkg;

  localparam logic [4:0] TIME_PAGE = 5'b01111;
  localparam int         BANK_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_COMMIT  = 3'd2,
    S_ABORT   = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  // Bank i powers up mapped to page i, giving a linear ROM map out of reset.
  function automatic logic [BANK_W-1:0] bank_rst_val(input int idx);
    return idx[BANK_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssf_sync.sv
// ssf_sync: N-stage synchronizer with asynchronous active-high reset to RST_VAL.
// Rev 1.0
`default_nettype none

module ssf_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/ssf_bank_ctrl.sv
// ssf_bank_ctrl: qualifies synchronized /TIME writes and commits SRAM control and banks 1..7.
// Optional register readback under SSF_READBACK_EN.  Rev 1.0
`default_nettype none

module ssf_bank_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int BANK_W        = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            cart_address,
  input  logic [15:0]           cart_data_in,
  input  logic                  tme,
  input  logic                  lwr,
  input  logic                  cas0,
  input  logic                  ce_0,
  output logic                  sram_enabled,
  output logic                  sram_writable,
  output logic [7*BANK_W-1:0]   banks_flat,
  output logic                  reg_wr,
  output logic                  wr_abort,
  output logic [15:0]           rd_data,
  output logic                  rd_oe
);

  import ssf_pkg::*;

  logic tme_s, lwr_s, cas0_s, ce_0_s;

  ssf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_tme
    (.clk(clk), .rst(rst), .d(tme),  .q(tme_s));
  ssf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lwr
    (.clk(clk), .rst(rst), .d(lwr),  .q(lwr_s));
  ssf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cas0
    (.clk(clk), .rst(rst), .d(cas0), .q(cas0_s));
  ssf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ce0
    (.clk(clk), .rst(rst), .d(ce_0), .q(ce_0_s));

  logic       page_hit, qual, lwr_prev, lwr_fall;
  logic [2:0] offset;

  assign page_hit = (cart_address[7:3] == TIME_PAGE);
  assign offset   = cart_address[2:0];
  assign qual     = ~tme_s & cas0_s & ce_0_s & page_hit;
  assign lwr_fall = ~lwr_s & lwr_prev;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      lwr_prev <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      lwr_prev <= lwr_s;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    reg_wr   = 1'b0;
    wr_abort = 1'b0;
    case (state)
      S_IDLE: begin
        if (lwr_fall && qual) begin
          state_nx = S_SETTLE;
          cnt_nx   = 4'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        // Any release or loss of qualification before the count expires is a glitch.
        if (lwr_s || !qual)   state_nx = S_ABORT;
        else if (cnt == 4'd0) state_nx = S_COMMIT;
        else                  cnt_nx   = cnt - 4'd1;
      end
      S_COMMIT: begin
        reg_wr   = 1'b1;
        state_nx = S_WAIT_HI;
      end
      S_ABORT: begin
        wr_abort = 1'b1;
        state_nx = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (lwr_s && tme_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  logic [BANK_W-1:0] bank [1:7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_enabled  <= 1'b0;
      sram_writable <= 1'b0;
      for (int i = 1; i <= 7; i++) bank[i] <= BANK_W'(bank_rst_val(i));
    end else if (reg_wr) begin
      // Address and data have been stable for the whole settle window by now.
      if (offset == 3'd0) {sram_writable, sram_enabled} <= cart_data_in[1:0];
      else                bank[offset] <= cart_data_in[BANK_W-1:0];
    end
  end

  for (genvar gi = 1; gi <= 7; gi++) begin : g_flat
    assign banks_flat[BANK_W*gi-1 -: BANK_W] = bank[gi];
  end

`ifdef SSF_READBACK_EN
  logic rd_hit, rd_oe_nx;

  assign rd_hit   = ~tme_s & ~cas0_s & page_hit;
  assign rd_oe_nx = rd_hit | (rd_oe & ~tme_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_oe   <= 1'b0;
      rd_data <= 16'h0000;
    end else begin
      rd_oe <= rd_oe_nx;
      if (!rd_oe_nx)         rd_data <= 16'h0000;
      else if (offset == 3'd0) rd_data <= {14'b0, sram_writable, sram_enabled};
      else                   rd_data <= {{(16-BANK_W){1'b0}}, bank[offset]};
    end
  end
`else
  assign rd_oe   = 1'b0;
  assign rd_data = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ssf_bank_ctrl.sv
// tb_ssf_bank_ctrl: directed self-checking bench for ssf_bank_ctrl (honours SSF_READBACK_EN).
`default_nettype none

module tb_ssf_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cart_address;
  logic [15:0] cart_data_in;
  logic        tme, lwr, cas0, ce_0;
  logic        sram_enabled, sram_writable, reg_wr, wr_abort, rd_oe;
  logic [41:0] banks_flat;
  logic [15:0] rd_data;

  ssf_bank_ctrl dut (
    .clk(clk), .rst(rst), .cart_address(cart_address), .cart_data_in(cart_data_in),
    .tme(tme), .lwr(lwr), .cas0(cas0), .ce_0(ce_0),
    .sram_enabled(sram_enabled), .sram_writable(sram_writable), .banks_flat(banks_flat),
    .reg_wr(reg_wr), .wr_abort(wr_abort), .rd_data(rd_data), .rd_oe(rd_oe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_wr   = 0;
  int n_ab   = 0;
  logic [5:0] exp_bank [1:7];

  always @(negedge clk) begin
    if (reg_wr)   n_wr++;
    if (wr_abort) n_ab++;
  end

  function automatic logic [41:0] exp_flat();
    logic [41:0] f;
    for (int i = 1; i <= 7; i++) f[6*i-1 -: 6] = exp_bank[i];
    return f;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_cycle(input logic [7:0] addr, input logic [15:0] data,
                          input logic tme_v, input logic ce_v, input int low_clks);
    @(negedge clk);
    cart_address = addr; cart_data_in = data; cas0 = 1'b1; ce_0 = ce_v; tme = tme_v;
    @(negedge clk);
    lwr = 1'b0;
    repeat (low_clks) @(negedge clk);
    lwr = 1'b1; tme = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  int wr0, ab0;

  initial begin
    rst = 1'b1; cart_address = 8'h00; cart_data_in = 16'h0000;
    tme = 1'b1; lwr = 1'b1; cas0 = 1'b0; ce_0 = 1'b0;
    for (int i = 1; i <= 7; i++) exp_bank[i] = 6'(i);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_banks", 64'(banks_flat), 64'(exp_flat()));
    check("rst_sram_en", 64'(sram_enabled), 64'd0);
    check("rst_sram_wr", 64'(sram_writable), 64'd0);
    check("rst_rd_oe", 64'(rd_oe), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_no_wr", 64'(n_wr), 64'd0);

    // $A130F2 offset 1, data 0x0025
    wr0 = n_wr; ab0 = n_ab;
    wr_cycle(8'h79, 16'h0025, 1'b0, 1'b1, 8);
    exp_bank[1] = 6'h25;
    check("bank1_wr_cnt", 64'(n_wr - wr0), 64'd1);
    check("bank1_ab_cnt", 64'(n_ab - ab0), 64'd0);
    check("bank1_banks", 64'(banks_flat), 64'(exp_flat()));

    // Offset 0: SRAM enable + writable, then writable cleared; upper data bits ignored on bank 5
    wr_cycle(8'h78, 16'h0003, 1'b0, 1'b1, 8);
    check("sram_en_1", 64'(sram_enabled), 64'd1);
    check("sram_wr_1", 64'(sram_writable), 64'd1);
    wr_cycle(8'h78, 16'h0001, 1'b0, 1'b1, 8);
    check("sram_en_2", 64'(sram_enabled), 64'd1);
    check("sram_wr_2", 64'(sram_writable), 64'd0);
    wr_cycle(8'h7D, 16'hFFD2, 1'b0, 1'b1, 8);
    exp_bank[5] = 6'h12;
    check("bank5_banks", 64'(banks_flat), 64'(exp_flat()));

    // Short /LWR pulse aborts
    wr0 = n_wr; ab0 = n_ab;
    wr_cycle(8'h7A, 16'h0011, 1'b0, 1'b1, 2);
    check("short_ab_cnt", 64'(n_ab - ab0), 64'd1);
    check("short_wr_cnt", 64'(n_wr - wr0), 64'd0);
    check("short_banks", 64'(banks_flat), 64'(exp_flat()));

    // Ignored writes: /TIME high, ROM space, wrong page
    wr0 = n_wr; ab0 = n_ab;
    wr_cycle(8'h7B, 16'h0033, 1'b1, 1'b1, 8);
    wr_cycle(8'h7B, 16'h0033, 1'b0, 1'b0, 8);
    wr_cycle(8'h01, 16'h003A, 1'b0, 1'b1, 8);
    check("ign_wr_cnt", 64'(n_wr - wr0), 64'd0);
    check("ign_ab_cnt", 64'(n_ab - ab0), 64'd0);
    check("ign_banks", 64'(banks_flat), 64'(exp_flat()));

    // Bank 7 write then readback
    wr_cycle(8'h7F, 16'h003F, 1'b0, 1'b1, 8);
    exp_bank[7] = 6'h3F;
    check("bank7_banks", 64'(banks_flat), 64'(exp_flat()));
    @(negedge clk);
    cart_address = 8'h7F; cas0 = 1'b0; ce_0 = 1'b1; tme = 1'b0;
    repeat (5) @(negedge clk);
`ifdef SSF_READBACK_EN
    check("rb_oe", 64'(rd_oe), 64'd1);
    check("rb_data", 64'(rd_data), 64'h003F);
`else
    check("rb_oe_off", 64'(rd_oe), 64'd0);
    check("rb_data_off", 64'(rd_data), 64'd0);
`endif
    tme = 1'b1;
    repeat (5) @(negedge clk);
    check("rb_oe_drop", 64'(rd_oe), 64'd0);

    // Reset during SETTLE
    wr0 = n_wr;
    @(negedge clk);
    cart_address = 8'h7C; cart_data_in = 16'h002A; cas0 = 1'b1; ce_0 = 1'b1; tme = 1'b0;
    @(negedge clk);
    lwr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 7; i++) exp_bank[i] = 6'(i);
    check("mid_rst_banks", 64'(banks_flat), 64'(exp_flat()));
    check("mid_rst_sram_en", 64'(sram_enabled), 64'd0);
    check("mid_rst_reg_wr", 64'(reg_wr), 64'd0);
    check("mid_rst_abort", 64'(wr_abort), 64'd0);
    lwr = 1'b1; tme = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_no_wr", 64'(n_wr - wr0), 64'd0);
    check("post_rst_banks", 64'(banks_flat), 64'(exp_flat()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
